// File: rtl/data_mem_responder_pkg.sv
// Shared types and default sizing for the data-memory responder.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DMEM_N          = 32;
  localparam int DMEM_ADDR_WIDTH = 32;
  localparam int DMEM_DEPTH      = 1024;
  localparam int DMEM_LATENCY    = 2;

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response bundle between the Memory stage and data memory.
interface data_mem_responder_if #(
  parameter int N          = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_addr_vld;
  logic                  i_wr_en;
  logic [3:0]            i_sel;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [N-1:0]          i_wdata;
  logic [N-1:0]          o_rdata;
  logic                  o_d_valid;
  logic                  o_busy;
  logic                  o_err;

  modport master (
    output i_addr_vld, i_wr_en, i_sel, i_addr, i_wdata,
    input  o_rdata, o_d_valid, o_busy, o_err
  );

  modport slave (
    input  i_addr_vld, i_wr_en, i_sel, i_addr, i_wdata,
    output o_rdata, o_d_valid, o_busy, o_err
  );
endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Word storage as four lane-wide banks: synchronous read-before-write, per-lane write enables, no reset.
module dmem_array #(
  parameter int N           = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic                           re,
  input  logic [3:0]                     we,
  input  logic [N-1:0]                   wdata,
  output logic [N-1:0]                   rdata
);
  localparam int LW = N / 4;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [LW-1:0] bank [DEPTH_WORDS];
    logic [LW-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (we[k]) bank[idx] <= wdata[k*LW +: LW];
      if (re)    rd_q      <= bank[idx];
    end

    assign rdata[k*LW +: LW] = rd_q;
  end
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store, fixed wait states, byte-lane stores.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int N           = DMEM_N,
  parameter int ADDR_WIDTH  = DMEM_ADDR_WIDTH,
  parameter int DEPTH_WORDS = DMEM_DEPTH,
  parameter int LATENCY     = DMEM_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_responder_if.slave bus
);
  localparam int         IW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  accept, commit;
  logic                  err_q, rd_zero_q;

  logic                  req_wr_p0;
  logic [3:0]            req_sel_p0;
  logic [ADDR_WIDTH-1:0] req_addr_p0;
  logic [N-1:0]          req_wdata_p0;

  logic                  c_wr;
  logic [3:0]            c_sel;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [N-1:0]          c_wdata;
  logic                  c_oor;

  logic [N-1:0]          arr_rdata;
  logic [3:0]            arr_we;
  logic                  arr_re;

  assign accept = bus.i_addr_vld && (state_q == ST_IDLE || state_q == ST_RESP);

  // Stage p0: request capture at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      req_wr_p0    <= bus.i_wr_en;
      req_sel_p0   <= bus.i_sel;
      req_addr_p0  <= bus.i_addr;
      req_wdata_p0 <= bus.i_wdata;
    end
  end

  // With no wait states the commit edge is the acceptance edge, so use the live request.
  always_comb begin
    if (LATENCY == 0) begin
      c_wr    = bus.i_wr_en;
      c_sel   = bus.i_sel;
      c_addr  = bus.i_addr;
      c_wdata = bus.i_wdata;
    end else begin
      c_wr    = req_wr_p0;
      c_sel   = req_sel_p0;
      c_addr  = req_addr_p0;
      c_wdata = req_wdata_p0;
    end
  end

  assign c_oor  = |(c_addr >> (IW + 2));
  assign commit = !rst && ((LATENCY == 0) ? accept : (state_q == ST_WAIT && cnt_q == 4'd0));
  assign arr_re = commit && !c_oor;
  assign arr_we = (commit && c_wr && !c_oor) ? c_sel : 4'b0000;

  dmem_array #(
    .N           (N),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .idx   (c_addr[IW+1:2]),
    .re    (arr_re),
    .we    (arr_we),
    .wdata (c_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        err_q     <= c_oor;
        rd_zero_q <= c_oor;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p1: response outputs; rdata reads as zero after reset or an out-of-range access
  always_comb begin
    bus.o_d_valid = (state_q == ST_RESP);
    bus.o_busy    = (state_q == ST_WAIT);
    bus.o_err     = (state_q == ST_RESP) && err_q;
    bus.o_rdata   = rd_zero_q ? '0 : arr_rdata;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 and LATENCY=0 instances against a word-array reference model.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int DEPTH = 1024;

  logic clk;
  logic rst2, rst0;
  int   n_vec = 0;
  int   n_bad = 0;

  logic [31:0] mem   [2][DEPTH];
  bit          known [2][DEPTH];

  data_mem_responder_if #(.N(32), .ADDR_WIDTH(32)) bus2 ();
  data_mem_responder_if #(.N(32), .ADDR_WIDTH(32)) bus0 ();

  data_mem_responder #(.N(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2.slave)
  );

  data_mem_responder #(.N(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: a flat word array; responses return the word as it was before this access.
  function automatic void model(input int d, input logic wr, input logic [3:0] sel,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] exp, output logic chk, output logic oor);
    int idx;
    oor = (addr / 4) >= DEPTH;
    idx = int'((addr / 4) % DEPTH);
    exp = oor ? 32'h0 : mem[d][idx];
    chk = oor || known[d][idx];
    if (wr && !oor) begin
      for (int k = 0; k < 4; k++)
        if (sel[k]) mem[d][idx][8*k +: 8] = wd[8*k +: 8];
      if (sel == 4'hF) known[d][idx] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return $urandom | 32'h0000_1000;
    return 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
  endfunction

  // One LATENCY=2 transaction, entered on a negedge while the DUT can accept.
  task automatic txn2(input logic wr, input logic [3:0] sel, input logic [31:0] addr,
                      input logic [31:0] wd, input int gap, output logic [31:0] rd_obs);
    logic [31:0] exp;
    logic        chk, oor, got;
    int          cyc, busy_n;
    model(0, wr, sel, addr, wd, exp, chk, oor);
    bus2.i_addr_vld = 1'b1;
    bus2.i_wr_en    = wr;
    bus2.i_sel      = sel;
    bus2.i_addr     = addr;
    bus2.i_wdata    = wd;
    cyc = 0; busy_n = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      bus2.i_addr_vld = 1'b0;
      cyc++;
      if (bus2.o_d_valid) got = 1'b1;
      else begin
        if (bus2.o_busy) busy_n++;
        check("err_without_valid", 32'(bus2.o_err), 32'd0);
      end
    end
    check("l2_latency", cyc, 3);
    check("l2_busy_cycles", busy_n, 2);
    if (chk) check("l2_rdata", bus2.o_rdata, exp);
    check("l2_err", 32'(bus2.o_err), 32'(oor));
    rd_obs = bus2.o_rdata;
    repeat (gap) @(negedge clk);
  endtask

  // One LATENCY=0 step with the request held high across steps.
  task automatic step0(input logic wr, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] wd);
    logic [31:0] exp;
    logic        chk, oor;
    model(1, wr, sel, addr, wd, exp, chk, oor);
    bus0.i_addr_vld = 1'b1;
    bus0.i_wr_en    = wr;
    bus0.i_sel      = sel;
    bus0.i_addr     = addr;
    bus0.i_wdata    = wd;
    @(negedge clk);
    check("l0_valid", 32'(bus0.o_d_valid), 32'd1);
    check("l0_not_idle", 32'(u_dut0.state_q != ST_IDLE), 32'd1);
    if (chk) check("l0_rdata", bus0.o_rdata, exp);
    check("l0_err", 32'(bus0.o_err), 32'(oor));
  endtask

  initial begin
    logic [31:0] rd, old20;
    int          dv;
    bus2.i_addr_vld = 1'b0; bus2.i_wr_en = 1'b0; bus2.i_sel = 4'h0; bus2.i_addr = '0; bus2.i_wdata = '0;
    bus0.i_addr_vld = 1'b0; bus0.i_wr_en = 1'b0; bus0.i_sel = 4'h0; bus0.i_addr = '0; bus0.i_wdata = '0;
    rst2 = 1'b1;
    rst0 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid2", 32'(bus2.o_d_valid), 32'd0);
    check("rst_busy2", 32'(bus2.o_busy), 32'd0);
    check("rst_err2", 32'(bus2.o_err), 32'd0);
    check("rst_rdata2", bus2.o_rdata, 32'd0);
    check("rst_state2", 32'(u_dut2.state_q), 32'(ST_IDLE));
    check("rst_cnt2", 32'(u_dut2.cnt_q), 32'd0);
    check("rst_valid0", 32'(bus0.o_d_valid), 32'd0);
    check("rst_rdata0", bus0.o_rdata, 32'd0);
    rst2 = 1'b0;
    rst0 = 1'b0;

    for (int w = 0; w < 16; w++) txn2(1'b1, 4'hF, 32'(w * 4), $urandom, 0, rd);

    txn2(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1, rd);
    txn2(1'b0, 4'h0, 32'h10, 32'h0, 0, rd);
    check("load_deadbeef", rd, 32'hDEADBEEF);

    txn2(1'b1, 4'b0001, 32'h10, 32'h000000AB, 0, rd);
    txn2(1'b1, 4'b0010, 32'h10, 32'h0000CD00, 2, rd);
    txn2(1'b0, 4'h0, 32'h10, 32'h0, 0, rd);
    check("byte_lanes", rd, 32'hDEADCDAB);

    txn2(1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 0, rd);
    check("oor_store_rdata", rd, 32'h0);
    txn2(1'b0, 4'h0, 32'h0000_1000, 32'h0, 0, rd);
    txn2(1'b0, 4'h0, 32'h0, 32'h0, 1, rd);

    old20 = mem[0][8];
    bus2.i_addr_vld = 1'b1; bus2.i_wr_en = 1'b1; bus2.i_sel = 4'hF;
    bus2.i_addr = 32'h20; bus2.i_wdata = 32'h12345678;
    @(negedge clk);
    bus2.i_addr_vld = 1'b0;
    check("midrst_busy_before", 32'(bus2.o_busy), 32'd1);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    check("midrst_valid_after", 32'(bus2.o_d_valid), 32'd0);
    check("midrst_busy_after", 32'(bus2.o_busy), 32'd0);
    dv = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus2.o_d_valid) dv++;
    end
    check("midrst_no_response", dv, 0);
    txn2(1'b0, 4'h0, 32'h20, 32'h0, 0, rd);
    check("midrst_old_data", rd, old20);

    txn2(1'b1, 4'hF, 32'h30, 32'h55AA55AA, 0, rd);
    txn2(1'b1, 4'h0, 32'h30, 32'h11111111, 0, rd);
    txn2(1'b0, 4'h0, 32'h30, 32'h0, 0, rd);
    check("sel_none", rd, 32'h55AA55AA);

    for (int i = 0; i < 40; i++)
      txn2(1'($urandom_range(0, 1)), 4'($urandom), rand_addr(), $urandom, $urandom_range(0, 2), rd);

    check("l0_idle_before", 32'(u_dut0.state_q), 32'(ST_IDLE));
    for (int w = 0; w < 16; w++) step0(1'b1, 4'hF, 32'(w * 4), $urandom);
    for (int w = 0; w < 4; w++) step0(1'b0, 4'h0, 32'(w * 4), 32'h0);
    for (int i = 0; i < 40; i++)
      step0(1'($urandom_range(0, 1)), 4'($urandom), rand_addr(), $urandom);
    step0(1'b1, 4'hF, 32'h8, 32'hCAFEF00D);
    step0(1'b0, 4'h0, 32'h8, 32'h0);
    bus0.i_addr_vld = 1'b0;
    @(negedge clk);
    check("l0_valid_drop", 32'(bus0.o_d_valid), 32'd0);
    check("l0_err_drop", 32'(bus0.o_err), 32'd0);
    check("l0_idle_after", 32'(u_dut0.state_q), 32'(ST_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
